// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_scan_pkg : seven-segment glyphs and width helper for the scan driver
// Rev 1.0
// ---------------------------------------------------------------------------
package seg_scan_pkg;

  // Bit order {dp,g,f,e,d,c,b,a}, active-high (1 = lit)
  localparam logic [7:0] GLYPH_HEX [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };
  localparam logic [7:0] GLYPH_BLANK = 8'h00;
  localparam logic [7:0] GLYPH_DASH  = 8'h40;
  localparam logic [7:0] DP_MASK     = 8'h80;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_pwm_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_scan_pwm_if : display data in, digit-select/segment pins out
// Rev 1.0
// ---------------------------------------------------------------------------
interface seg_scan_pwm_if #(
  parameter int NUM_DIGITS = 6
);
  logic [8*NUM_DIGITS-1:0] seg_data_flat;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [3:0]              brightness;
  logic [NUM_DIGITS-1:0]   seg_sel;
  logic [7:0]              seg_data;
  logic                    frame_start;

  modport master (
    output seg_data_flat, digit_en, brightness,
    input  seg_sel, seg_data, frame_start
  );

  modport slave (
    input  seg_data_flat, digit_en, brightness,
    output seg_sel, seg_data, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_timebase.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_scan_timebase : slot timer and digit index with slot/frame strobes
// Rev 1.0
// ---------------------------------------------------------------------------
module seg_scan_timebase
  import seg_scan_pkg::*;
#(
  parameter int SLOT_CYCLES = 16,
  parameter int NUM_DIGITS  = 4,
  parameter int TW          = idx_width(SLOT_CYCLES),
  parameter int IW          = idx_width(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [TW-1:0] slot_timer,
  output logic [IW-1:0] idx,
  output logic          slot_start,
  output logic          frame_boundary
);

  localparam logic [TW-1:0] LAST_T = TW'(SLOT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_I = IW'(NUM_DIGITS - 1);

  logic [TW-1:0] slot_timer_q, slot_timer_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    slot_timer_d = slot_timer_q + TW'(1);
    idx_d        = idx_q;
    if (slot_timer_q == LAST_T) begin
      slot_timer_d = '0;
      idx_d        = (idx_q == LAST_I) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_timer_q <= '0;
      idx_q        <= '0;
    end else begin
      slot_timer_q <= slot_timer_d;
      idx_q        <= idx_d;
    end
  end

  assign slot_timer     = slot_timer_q;
  assign idx            = idx_q;
  assign slot_start     = (slot_timer_q == '0);
  assign frame_boundary = (slot_timer_q == '0) && (idx_q == '0);

endmodule
`default_nettype wire

// File: rtl/seg_scan_pwm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_scan_pwm : multiplexed 7-seg driver with blanking, PWM and shadowing
// Rev 1.0
// ---------------------------------------------------------------------------
module seg_scan_pwm
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int CLK_FREQ       = 50_000_000,
  parameter int SCAN_FREQ      = 200,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_pwm_if.slave  bus
);

  localparam int SLOT_CYCLES = CLK_FREQ / (SCAN_FREQ * NUM_DIGITS);
  localparam int ON_CYCLES   = SLOT_CYCLES - BLANK_CYCLES;
  localparam int TW          = idx_width(SLOT_CYCLES);
  localparam int IW          = idx_width(NUM_DIGITS);
  localparam int PW          = TW + 4;

  localparam logic [TW-1:0]         BLANK_T  = TW'(BLANK_CYCLES);
  localparam logic [NUM_DIGITS-1:0] SEL_MASK = {NUM_DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [7:0]            SEG_MASK = {8{SEG_ACTIVE_LOW}};

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
    $error("seg_scan_pwm: NUM_DIGITS must be 1..16");
  end
  if (SLOT_CYCLES <= BLANK_CYCLES) begin : g_bad_blank
    $error("seg_scan_pwm: slot length must exceed BLANK_CYCLES");
  end

  logic [TW-1:0] slot_timer;
  logic [IW-1:0] idx;
  logic          slot_start;
  logic          frame_boundary;

  seg_scan_timebase #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .NUM_DIGITS  (NUM_DIGITS),
    .TW          (TW),
    .IW          (IW)
  ) u_timebase (
    .clk            (clk),
    .rst_n          (rst_n),
    .slot_timer     (slot_timer),
    .idx            (idx),
    .slot_start     (slot_start),
    .frame_boundary (frame_boundary)
  );

  logic [8*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0]   shadow_en_q, shadow_en_d;
  logic [TW-1:0]           lit_len_q, lit_len_d;
  logic [NUM_DIGITS-1:0]   seg_sel_q, seg_sel_d;
  logic [7:0]              seg_data_q, seg_data_d;
  logic                    frame_start_q, frame_start_d;

  logic [PW-1:0]         lit_prod;
  logic [7:0]            cur_pat;
  logic                  cur_en;
  logic [NUM_DIGITS-1:0] cur_onehot;
  logic                  lit;

  // The slot-start cycle already decides with the values being captured, so
  // BLANK_CYCLES=0 lights the new digit from its very first cycle.
  always_comb begin
    shadow_data_d = frame_boundary ? bus.seg_data_flat : shadow_data_q;
    shadow_en_d   = frame_boundary ? bus.digit_en      : shadow_en_q;
    lit_prod      = (PW'(bus.brightness) + PW'(1)) * PW'(ON_CYCLES);
    lit_len_d     = slot_start ? TW'(lit_prod >> 4) : lit_len_q;

    cur_pat    = '0;
    cur_en     = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_pat       = shadow_data_d[8*i +: 8];
        cur_en        = shadow_en_d[i];
        cur_onehot[i] = 1'b1;
      end
    end

    lit = cur_en && (slot_timer >= BLANK_T) && ((slot_timer - BLANK_T) < lit_len_d);

    seg_sel_d     = (lit ? cur_onehot : '0) ^ SEL_MASK;
    seg_data_d    = (lit ? cur_pat : 8'h00) ^ SEG_MASK;
    frame_start_d = frame_boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data_q <= '0;
      shadow_en_q   <= '0;
      lit_len_q     <= '0;
      seg_sel_q     <= SEL_MASK;
      seg_data_q    <= SEG_MASK;
      frame_start_q <= 1'b0;
    end else begin
      shadow_data_q <= shadow_data_d;
      shadow_en_q   <= shadow_en_d;
      lit_len_q     <= lit_len_d;
      seg_sel_q     <= seg_sel_d;
      seg_data_q    <= seg_data_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg_sel     = seg_sel_q;
  assign bus.seg_data    = seg_data_q;
  assign bus.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_pwm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seg_scan_pwm : scoreboard bench, active-low and active-high instances
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_seg_scan_pwm;

  localparam int N     = 4;
  localparam int BLANK = 4;
  localparam int SLOT  = 16;
  localparam int ON    = 12;
  localparam int FRAME = SLOT * N;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] data;
    logic       fs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = 32'h0;
  logic [3:0]  en = 4'h0;
  logic [3:0]  bright = 4'h0;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];

  int          m_timer = 0;
  int          m_idx = 0;
  logic [31:0] m_sh_data = '0;
  logic [3:0]  m_sh_en = '0;
  int          m_lit_len = 0;

  seg_scan_pwm_if #(.NUM_DIGITS(N)) if_lo ();
  seg_scan_pwm_if #(.NUM_DIGITS(N)) if_hi ();

  assign if_lo.seg_data_flat = data;
  assign if_lo.digit_en      = en;
  assign if_lo.brightness    = bright;
  assign if_hi.seg_data_flat = data;
  assign if_hi.digit_en      = en;
  assign if_hi.brightness    = bright;

  seg_scan_pwm #(
    .NUM_DIGITS(N), .CLK_FREQ(6400), .SCAN_FREQ(100), .BLANK_CYCLES(BLANK),
    .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) u_dut_lo (.clk(clk), .rst_n(rst_n), .bus(if_lo.slave));

  seg_scan_pwm #(
    .NUM_DIGITS(N), .CLK_FREQ(6400), .SCAN_FREQ(100), .BLANK_CYCLES(BLANK),
    .SEL_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)
  ) u_dut_hi (.clk(clk), .rst_n(rst_n), .bus(if_hi.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one step per rising edge, expectation for the registered outputs
  initial begin
    exp_t e;
    logic lit;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_timer = 0; m_idx = 0; m_sh_data = '0; m_sh_en = '0; m_lit_len = 0;
        exp_q.delete();
      end else begin
        if (m_timer == 0) begin
          if (m_idx == 0) begin
            m_sh_data = data;
            m_sh_en   = en;
          end
          m_lit_len = ((int'(bright) + 1) * ON) / 16;
        end
        lit    = m_sh_en[m_idx] && (m_timer >= BLANK) && ((m_timer - BLANK) < m_lit_len);
        e.sel  = lit ? (4'b0001 << m_idx) : 4'b0000;
        e.data = lit ? m_sh_data[8*m_idx +: 8] : 8'h00;
        e.fs   = (m_timer == 0) && (m_idx == 0);
        exp_q.push_back(e);
        m_timer++;
        if (m_timer == SLOT) begin
          m_timer = 0;
          m_idx   = (m_idx + 1) % N;
        end
      end
    end
  end

  // Output checker on the falling edge
  initial begin
    exp_t e;
    int cyc = 0;
    int last_fs = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check("rst_sel_lo", 32'(if_lo.seg_sel), 32'hF);
        check("rst_seg_lo", 32'(if_lo.seg_data), 32'hFF);
        check("rst_fs_lo", 32'(if_lo.frame_start), 32'h0);
        check("rst_sel_hi", 32'(if_hi.seg_sel), 32'h0);
        check("rst_seg_hi", 32'(if_hi.seg_data), 32'h00);
        last_fs = -1;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sel_lo", 32'(if_lo.seg_sel), 32'(e.sel ^ 4'hF));
        check("seg_lo", 32'(if_lo.seg_data), 32'(e.data ^ 8'hFF));
        check("fs_lo", 32'(if_lo.frame_start), 32'(e.fs));
        check("sel_hi", 32'(if_hi.seg_sel), 32'(e.sel));
        check("seg_hi", 32'(if_hi.seg_data), 32'(e.data));
        check("fs_hi", 32'(if_hi.frame_start), 32'(e.fs));
        if (e.fs) begin
          if (last_fs >= 0) check("fs_period", 32'(cyc - last_fs), 32'(FRAME));
          last_fs = cyc;
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stops at the falling edge where the model's next state is (idx, tmr)
  task automatic wait_state(input int idx, input int tmr);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_idx == idx && m_timer == tmr) && n < 4 * FRAME);
    check("wait_idx", 32'(m_idx), 32'(idx));
    check("wait_tmr", 32'(m_timer), 32'(tmr));
  endtask

  initial begin
    data   = {8'h4F, 8'h5B, 8'h06, 8'h3F};
    en     = 4'hF;
    bright = 4'd15;
    run(3);
    #2 rst_n = 1'b1;
    run(2 * FRAME);

    // brightness change mid-slot takes effect from the next slot
    wait_state(1, 9);
    bright = 4'd7;
    run(2 * FRAME);
    bright = 4'd0;
    run(2 * FRAME);

    bright = 4'd15;
    en     = 4'b0101;
    run(2 * FRAME);

    // new data during slot 2 must wait for the next frame
    en = 4'hF;
    run(FRAME);
    wait_state(2, 3);
    data = {8'h07, 8'h7D, 8'h6D, 8'h66};
    run(2 * FRAME);

    en = 4'h0;
    run(2 * FRAME);

    // asynchronous reset during a lit cycle of slot 2
    en = 4'hF;
    run(FRAME);
    wait_state(2, 8);
    check("pre_rst_sel_lo", 32'(if_lo.seg_sel), 32'hB);
    #2 rst_n = 1'b0;
    #1;
    check("async_sel_lo", 32'(if_lo.seg_sel), 32'hF);
    check("async_seg_lo", 32'(if_lo.seg_data), 32'hFF);
    check("async_sel_hi", 32'(if_hi.seg_sel), 32'h0);
    check("async_seg_hi", 32'(if_hi.seg_data), 32'h00);
    data = {8'h71, 8'h79, 8'h5E, 8'h39};
    run(3);
    #2 rst_n = 1'b1;
    run(2 * FRAME);

    run(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_pwm.md
Name: seg_scan_pwm

Overview:
Parametrised time-multiplexed driver for common-select seven-segment displays (segments a–g plus dp).
- Adds over the existing fixed 6-digit scanner:
  - configurable digit count and output polarity
  - anti-ghosting blank interval at the start of each digit slot
  - 16-level brightness PWM
  - per-digit enable
  - frame-coherent shadowing of the display data
- Sits between the clock/calendar formatting logic and the board's digit-select/segment pins.

Parameters:
- NUM_DIGITS, 6: number of digits scanned; legal 1..16.
- CLK_FREQ, 50_000_000: clk frequency in Hz.
- SCAN_FREQ, 200: full-frame refresh rate in Hz.
- BLANK_CYCLES, 500: cycles at the start of each slot during which all selects and segments are inactive.
- SEL_ACTIVE_LOW, 1: 1 means an active digit select is driven 0.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment is driven 0.
- Derived SLOT_CYCLES = CLK_FREQ/(SCAN_FREQ*NUM_DIGITS). Elaboration error unless SLOT_CYCLES > BLANK_CYCLES.
- Derived ON_CYCLES = SLOT_CYCLES - BLANK_CYCLES.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- seg_data_flat, in, 8*NUM_DIGITS: digit i pattern at [8i+7:8i]. Active-high internally: 1 = lit; bit7 = dp.
- digit_en, in, NUM_DIGITS: 1 = digit i displayed.
- brightness, in, 4: 0..15 PWM level.
- seg_sel, out, NUM_DIGITS: digit select; polarity set by SEL_ACTIVE_LOW.
- seg_data, out, 8: segment drive; polarity set by SEG_ACTIVE_LOW.
- frame_start, out, 1: one-cycle pulse at each frame boundary.

Behaviour:

Reset:
- slot_timer=0, idx=0, shadow registers=0, lit_len=0.
- seg_sel = all inactive (all 1s when SEL_ACTIVE_LOW=1).
- seg_data = all inactive (8'hFF when SEG_ACTIVE_LOW=1).
- frame_start = 0.

Timebase:
- slot_timer counts 0..SLOT_CYCLES-1, then wraps to 0 and advances idx.
- idx wraps from NUM_DIGITS-1 to 0.
- Disabled digits still consume their slot, so the refresh rate is constant.

Slot start (state slot_timer==0):
- If idx==0 (frame boundary): capture seg_data_flat and digit_en into the shadow registers.
- At every slot start: sample brightness and set lit_len = ((brightness+1)*ON_CYCLES)>>4, using a width sufficient to avoid overflow.
- Mid-slot changes to brightness have no effect. Mid-frame changes to data or enables have no effect until the next frame.
- The first slot-0 state after reset release is a frame boundary and performs the capture.

Lit condition:
- lit = shadow_en[idx] && slot_timer >= BLANK_CYCLES && (slot_timer - BLANK_CYCLES) < lit_len.
- lit_len may be 0 (dark) at low brightness when ON_CYCLES < 16.
- The lit decision uses the shadow_en and lit_len values captured at this slot's start.

Outputs (all registered, 1-cycle latency from the state cycle):
- seg_sel: one-hot at bit idx when lit, else all inactive. Polarity applied by XOR with SEL_ACTIVE_LOW.
- seg_data: shadow pattern for idx when lit, else 0 (all inactive). Polarity applied by XOR with SEG_ACTIVE_LOW.
- frame_start: 1 in the cycle after state (idx=0, slot_timer=0).

Boundary conditions:
- Select and segments are never both active across a digit change; BLANK_CYCLES ≥ 1 guarantees a gap.
- If BLANK_CYCLES=0 the change is direct, with no glitch, because the outputs are single-register.
- All digits disabled: outputs stay inactive; frame_start keeps pulsing.
- NUM_DIGITS=1: idx stays 0; every slot is a frame boundary.
- Asynchronous reset mid-slot: outputs go inactive immediately; the scan restarts at idx 0.

Decomposition:
- Package seg_scan_pkg: 7-seg glyph constants (hex 0–F, blank, dash, dp mask) and a function computing the index width (clog2, minimum 1).
- Sub-module seg_scan_timebase: slot_timer, idx, and slot_start/frame_start strobes.
- Top module: shadow registers, PWM compare, output registers.

Test Plan (CLK_FREQ=6400, SCAN_FREQ=100, NUM_DIGITS=4, BLANK_CYCLES=4 → SLOT=16, ON=12):
1. Reset held, then released, all 4 digits enabled, brightness=15, data 3F,06,5B,4F:
   - frame_start high 1 cycle after the first slot-0 state.
   - Each slot: 4 cycles blank, then 12 cycles of seg_sel=~(1<<i), seg_data=~pattern_i.
   - Period 64 cycles.
2. brightness=7 (lit_len=6), then brightness=0 (lit_len=0):
   - brightness=7: 6 lit cycles per slot, then 6 inactive.
   - brightness=0: outputs permanently inactive.
   - brightness changed mid-slot: the change applies from the next slot only.
3. digit_en=4'b0101:
   - slots 1 and 3 fully inactive; slot timing unchanged; frame_start every 64 cycles.
4. seg_data_flat changed during slot 2:
   - digits 2 and 3 keep showing the old values until after the next frame_start.
   - the new values appear from slot 0 of the next frame.
5. rst_n asserted during a lit cycle of slot 2:
   - seg_sel=4'hF and seg_data=8'hFF immediately (asynchronous).
   - after release, the scan restarts at digit 0 with a fresh capture.
6. SEL_ACTIVE_LOW=0, SEG_ACTIVE_LOW=0, brightness=15, all digits enabled:
   - reset values 0/0; lit drive seg_sel=(1<<i), seg_data=pattern_i.
